// File: rtl/score_bcd.sv
// score_bcd
//   Score keeper plus sequential binary-to-BCD converter that feeds the
//   32-bit x word of the seven-segment display driver.
//
//   Ports
//     clk, rst         : clock, asynchronous active-high reset
//     game_start       : pulse, clears the score and starts a game
//     game_over        : pulse, stops the game and commits the high score
//     inc              : pulse, adds STEP points while a game is running
//     show_high        : level, 1 displays the high score, 0 the current score
//     x[31:0]          : [15:0] four BCD digits, [31:16] legend/all-on enable
//     running          : game in progress
//     score, high      : binary current score and high score
//     upd              : one-cycle pulse whenever x is reloaded
module score_bcd #(
  parameter int W    = 14,
  parameter int MAX  = 9999,
  parameter int STEP = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         game_start,
  input  logic         game_over,
  input  logic         inc,
  input  logic         show_high,
  output logic [31:0]  x,
  output logic         running,
  output logic [W-1:0] score,
  output logic [W-1:0] high,
  output logic         upd
);

  localparam int CNT_W = $clog2(W + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   bin_q, bin_d;
  logic [15:0]    bcd_q, bcd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic           sel_q, sel_d;
  logic [31:0]    x_q, x_d;
  logic           upd_q, upd_d;
  logic [W-1:0]   score_q, score_d;
  logic [W-1:0]   high_q, high_d;
  logic           running_q, running_d;

  logic [W:0]     sum;
  logic [15:0]    bcd_adj;

  // Score bookkeeping. game_over commits the high score from the pre-edge
  // score before game_start gets a chance to clear it, so a simultaneous
  // end/restart keeps the finished game's result. The sum carries one
  // extra bit so saturation at MAX can never be fooled by a wrap.
  always_comb begin
    score_d   = score_q;
    high_d    = high_q;
    running_d = running_q;
    sum       = {1'b0, score_q} + (W+1)'(STEP);

    if (game_over) begin
      if (score_q > high_q) high_d = score_q;
      running_d = 1'b0;
    end

    if (game_start) begin
      score_d   = '0;
      running_d = 1'b1;
    end else if (inc && running_q) begin
      score_d = (sum > (W+1)'(MAX)) ? W'(MAX) : sum[W-1:0];
    end
  end

  // Free-running double-dabble converter. IDLE snapshots the selected
  // source so changes during SHIFT only show up in the next conversion.
  // Each SHIFT cycle applies the +3 correction to every nibble of 5 or
  // more, then shifts the combined {bcd, bin} register left by one.
  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    x_d     = x_q;
    upd_d   = 1'b0;

    bcd_adj = bcd_q;
    for (int i = 0; i < 4; i++) begin
      if (bcd_adj[i*4 +: 4] >= 4'd5) bcd_adj[i*4 +: 4] = bcd_adj[i*4 +: 4] + 4'd3;
    end

    case (state_q)
      IDLE: begin
        bin_d   = show_high ? high_q : score_q;
        bcd_d   = '0;
        cnt_d   = '0;
        sel_d   = show_high;
        state_d = SHIFT;
      end
      SHIFT: begin
        {bcd_d, bin_d} = {bcd_adj, bin_q} << 1;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(W - 1)) state_d = DONE;
      end
      DONE: begin
        x_d     = {(sel_q ? 16'hFFFF : 16'h0000), bcd_q};
        upd_d   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // All state registers, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      bin_q     <= '0;
      bcd_q     <= '0;
      cnt_q     <= '0;
      sel_q     <= 1'b0;
      x_q       <= '0;
      upd_q     <= 1'b0;
      score_q   <= '0;
      high_q    <= '0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      bin_q     <= bin_d;
      bcd_q     <= bcd_d;
      cnt_q     <= cnt_d;
      sel_q     <= sel_d;
      x_q       <= x_d;
      upd_q     <= upd_d;
      score_q   <= score_d;
      high_q    <= high_d;
      running_q <= running_d;
    end
  end

  assign x       = x_q;
  assign upd     = upd_q;
  assign score   = score_q;
  assign high    = high_q;
  assign running = running_q;

endmodule
